// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries in program order, captures
// RS/LSB result broadcasts, answers operand queries and retires one entry
// per cycle to the register file or store path, flushing on a mispredict.
module reorder_buffer #(
  parameter int unsigned ROB_SIZE_LOG = 4
) (
  input  logic                    clockIn,
  input  logic                    resetIn,
  input  logic                    addValid,
  input  logic [1:0]              addType,
  input  logic                    addReady,
  input  logic [31:0]             addValue,
  input  logic [4:0]              addDest,
  input  logic [31:0]             addAddr,
  output logic                    full,
  output logic [ROB_SIZE_LOG-1:0] next,
  input  logic [ROB_SIZE_LOG-1:0] requestIndex,
  output logic                    requestReady,
  output logic [31:0]             requestValue,
  input  logic                    rsUpdate,
  input  logic [ROB_SIZE_LOG-1:0] rsRobIndex,
  input  logic [31:0]             rsUpdateVal,
  input  logic                    lsbUpdate,
  input  logic [ROB_SIZE_LOG-1:0] lsbRobIndex,
  input  logic [31:0]             lsbUpdateVal,
  output logic                    rfCommitValid,
  output logic [4:0]              rfCommitDest,
  output logic [ROB_SIZE_LOG-1:0] rfCommitIndex,
  output logic [31:0]             rfCommitValue,
  output logic                    storeCommitValid,
  output logic [ROB_SIZE_LOG-1:0] storeCommitIndex,
  output logic                    flushOut,
  output logic [31:0]             flushAddr
);

  localparam int unsigned ROB_SIZE = 1 << ROB_SIZE_LOG;
  localparam int unsigned IDX_W    = ROB_SIZE_LOG;
  localparam int unsigned CNT_W    = ROB_SIZE_LOG + 1;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;

  localparam logic [1:0] TYPE_REG    = 2'b00;
  localparam logic [1:0] TYPE_BRANCH = 2'b01;
  localparam logic [1:0] TYPE_STORE  = 2'b10;

  typedef struct packed {
    logic [1:0]        kind;
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] value;
    logic [DATA_W-1:0] addr;
  } entryT;

  entryT               entries [ROB_SIZE];
  logic [ROB_SIZE-1:0] busyVec;
  logic [ROB_SIZE-1:0] readyVec;
  logic [IDX_W-1:0]    head;
  logic [IDX_W-1:0]    tail;
  logic [CNT_W-1:0]    count;

  entryT               headEntry;
  logic                doCommit;
  logic                doFlush;
  logic                doAlloc;
  logic                rsLsbSame;
  logic [ROB_SIZE-1:0] rsCapture;
  logic [ROB_SIZE-1:0] lsbCapture;
  logic [CNT_W-1:0]    countNext;

  // Issue-side status: one entry of slack behind the registered issue add.
  always_comb begin
    full = (count >= CNT_W'(ROB_SIZE - 1));
    next = tail;
  end

  // Retire, flush and allocate decisions for this cycle.
  always_comb begin
    headEntry = entries[head];
    doCommit  = busyVec[head] && readyVec[head];
    doFlush   = doCommit && (headEntry.kind == TYPE_BRANCH) && headEntry.value[0];
    doAlloc   = addValid && (count < CNT_W'(ROB_SIZE)) && !flushOut && !doFlush;
    rsLsbSame = rsUpdate && lsbUpdate && (rsRobIndex == lsbRobIndex);
    case ({doAlloc, doCommit})
      2'b10:   countNext = count + CNT_W'(1);
      2'b01:   countNext = count - CNT_W'(1);
      default: countNext = count;
    endcase
  end

  // Per-entry result capture; RS takes precedence over LSB on the same index.
  always_comb begin
    rsCapture  = '0;
    lsbCapture = '0;
    for (int i = 0; i < ROB_SIZE; i++) begin
      rsCapture[i]  = rsUpdate && (rsRobIndex == IDX_W'(i)) && busyVec[i] && !readyVec[i];
      lsbCapture[i] = lsbUpdate && !rsLsbSame && (lsbRobIndex == IDX_W'(i)) &&
                      busyVec[i] && !readyVec[i];
    end
  end

  // Zero-latency operand query with broadcast bypass (RS, then LSB, then stored).
  always_comb begin
    requestReady = 1'b0;
    requestValue = '0;
    if (!resetIn) begin
      requestReady = 1'b0;
    end else if (rsUpdate && (rsRobIndex == requestIndex)) begin
      requestReady = 1'b1;
      requestValue = rsUpdateVal;
    end else if (lsbUpdate && (lsbRobIndex == requestIndex)) begin
      requestReady = 1'b1;
      requestValue = lsbUpdateVal;
    end else if (busyVec[requestIndex] && readyVec[requestIndex]) begin
      requestReady = 1'b1;
      requestValue = entries[requestIndex].value;
    end
  end

  // Head/tail/count pointers; a flush empties the buffer.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (doFlush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (doAlloc)  tail <= tail + IDX_W'(1);
      if (doCommit) head <= head + IDX_W'(1);
      count <= countNext;
    end
  end

  // Entry storage: retire frees, broadcasts fill, allocation overwrites last.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      busyVec  <= '0;
      readyVec <= '0;
      for (int i = 0; i < ROB_SIZE; i++) entries[i] <= '0;
    end else if (doFlush) begin
      busyVec  <= '0;
      readyVec <= '0;
    end else begin
      for (int i = 0; i < ROB_SIZE; i++) begin
        if (doCommit && (head == IDX_W'(i))) begin
          busyVec[i]  <= 1'b0;
          readyVec[i] <= 1'b0;
        end
        if (rsCapture[i]) begin
          readyVec[i]       <= 1'b1;
          entries[i].value  <= rsUpdateVal;
        end else if (lsbCapture[i]) begin
          readyVec[i]       <= 1'b1;
          entries[i].value  <= lsbUpdateVal;
        end
        if (doAlloc && (tail == IDX_W'(i))) begin
          busyVec[i]  <= 1'b1;
          readyVec[i] <= addReady;
          entries[i]  <= '{kind: addType, dest: addDest, value: addValue, addr: addAddr};
        end
      end
    end
  end

  // Registered retire outputs; every pulse and its payload is zero without a commit.
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      rfCommitValid    <= 1'b0;
      rfCommitDest     <= '0;
      rfCommitIndex    <= '0;
      rfCommitValue    <= '0;
      storeCommitValid <= 1'b0;
      storeCommitIndex <= '0;
      flushOut         <= 1'b0;
      flushAddr        <= '0;
    end else begin
      rfCommitValid    <= 1'b0;
      rfCommitDest     <= '0;
      rfCommitIndex    <= '0;
      rfCommitValue    <= '0;
      storeCommitValid <= 1'b0;
      storeCommitIndex <= '0;
      flushOut         <= 1'b0;
      flushAddr        <= '0;
      if (doCommit) begin
        case (headEntry.kind)
          TYPE_REG: begin
            if (headEntry.dest != '0) begin
              rfCommitValid <= 1'b1;
              rfCommitDest  <= headEntry.dest;
              rfCommitIndex <= head;
              rfCommitValue <= headEntry.value;
            end
          end
          TYPE_STORE: begin
            storeCommitValid <= 1'b1;
            storeCommitIndex <= head;
          end
          TYPE_BRANCH: begin
            if (headEntry.value[0]) begin
              flushOut  <= 1'b1;
              flushAddr <= headEntry.addr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
